serial_tx: RTL and testbench

//  Framed serial transmitter: accepts a WIDTH-bit word on a valid/ready handshake and shifts it out
//  on a single line as start bit, data (LSB first), optional parity, then stop bit(s).

---
 rtl/serial_pkg.sv | 20 ++
 rtl/bit_timer.sv | 28 ++
 rtl/serial_tx.sv | 118 +++++++++++
 tb/tb_serial_tx.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the single-bit serial link (transmitter and receiver).
// State encodings are plain constants so older tools and the receiver can share them.
package serial_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

    // Seed XORed into the data reduction to form the parity bit.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/bit_timer.sv
// Per-bit cycle counter: counts 0..CLKS_PER_BIT-1, wraps, and ticks on the last cycle of a bit.
module bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    assign tick = !clear && (count == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Framed serial transmitter: start bit, WIDTH data bits LSB first, optional parity, stop bit(s).
// Accepts one word per frame on a valid/ready handshake; the line idles high.
module serial_tx
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             tx_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(WIDTH);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic PAR_INIT = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bit_cnt;
    logic             par_bit;
    logic             tick;

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

    // Timer is held at zero while idle so the start bit gets a full bit period from accept.
    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .clear(in_ready),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            tx_out  <= LINE_IDLE;
            done    <= 1'b0;
            shreg   <= '0;
            bit_cnt <= '0;
            par_bit <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state   <= ST_START;
                        shreg   <= in_data;
                        par_bit <= (^in_data) ^ PAR_INIT;
                        tx_out  <= START_BIT;
                        bit_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state   <= ST_DATA;
                        tx_out  <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= BW'(1);
                    end
                end
                ST_DATA: begin
                    // bit_cnt holds the number of data bits already placed on the line.
                    if (tick) begin
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                state  <= ST_PARITY;
                                tx_out <= par_bit;
                            end else begin
                                state  <= ST_STOP;
                                tx_out <= LINE_IDLE;
                            end
                        end else begin
                            tx_out  <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        state   <= ST_STOP;
                        tx_out  <= LINE_IDLE;
                        bit_cnt <= '0;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (bit_cnt == LAST_STOP) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    tx_out <= LINE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: four configurations, directed and random frames checked against a
// bit-list model of the frame format.
module tb_serial_tx;

    localparam int CPB   [4] = '{4, 4, 4, 1};
    localparam int PEN   [4] = '{0, 1, 1, 0};
    localparam int PODD  [4] = '{0, 0, 1, 0};
    localparam int STOPS [4] = '{1, 1, 1, 2};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] din [4];
    logic [3:0] vld;
    logic [3:0] rdy;
    logic [3:0] tx;
    logic [3:0] busy;
    logic [3:0] done;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) d0 (
        .clk(clk), .reset(reset), .in_data(din[0]), .in_valid(vld[0]), .in_ready(rdy[0]),
        .tx_out(tx[0]), .busy(busy[0]), .done(done[0])
    );
    serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) d1 (
        .clk(clk), .reset(reset), .in_data(din[1]), .in_valid(vld[1]), .in_ready(rdy[1]),
        .tx_out(tx[1]), .busy(busy[1]), .done(done[1])
    );
    serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) d2 (
        .clk(clk), .reset(reset), .in_data(din[2]), .in_valid(vld[2]), .in_ready(rdy[2]),
        .tx_out(tx[2]), .busy(busy[2]), .done(done[2])
    );
    serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) d3 (
        .clk(clk), .reset(reset), .in_data(din[3]), .in_valid(vld[3]), .in_ready(rdy[3]),
        .tx_out(tx[3]), .busy(busy[3]), .done(done[3])
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    endtask

    // Line value of frame bit b: start, data LSB first, optional parity, then stop/idle.
    function automatic logic exp_bit(input int k, input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (PEN[k] != 0 && b == 9) return ((($countones(d) + PODD[k]) % 2) == 1);
        return 1'b1;
    endfunction

    function automatic int frame_len(input int k);
        return CPB[k] * (1 + 8 + PEN[k] + STOPS[k]);
    endfunction

    // Called at a negedge with instance k idle; ends at the negedge of the done cycle.
    // mode 0: valid dropped after accept; 1: valid held with same data; 2: random valid/data.
    task automatic run_frame(input int k, input logic [7:0] data, input int mode);
        int f;
        f = frame_len(k);
        din[k] = data;
        vld[k] = 1'b1;
        check("ready_idle", rdy[k], 1'b1);
        @(posedge clk);
        #1;
        if (mode == 0) vld[k] = 1'b0;
        for (int i = 0; i < f; i++) begin
            @(negedge clk);
            check("tx_bit", tx[k], exp_bit(k, data, i / CPB[k]));
            check("busy_frame", busy[k], 1'b1);
            check("ready_busy", rdy[k], 1'b0);
            check("done_early", done[k], 1'b0);
            if (mode == 2) begin
                vld[k] = 1'($urandom);
                din[k] = 8'($urandom);
            end
        end
        @(negedge clk);
        check("done_pulse", done[k], 1'b1);
        check("busy_done", busy[k], 1'b0);
        check("tx_done", tx[k], 1'b1);
        check("ready_done", rdy[k], 1'b1);
        vld[k] = 1'b0;
    endtask

    task automatic idle_cycles(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_tx", tx[k], 1'b1);
            check("idle_busy", busy[k], 1'b0);
            check("idle_done", done[k], 1'b0);
        end
    endtask

    initial begin
        vld = '0;
        for (int k = 0; k < 4; k++) din[k] = 8'h00;

        // Reset held with a word offered: nothing may start.
        reset = 1'b1;
        vld[0] = 1'b1;
        din[0] = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_tx", tx[0], 1'b1);
            check("rst_busy", busy[0], 1'b0);
            check("rst_done", done[0], 1'b0);
        end
        vld[0] = 1'b0;
        reset = 1'b0;
        idle_cycles(0, 3);

        run_frame(0, 8'hA5, 0);
        @(negedge clk);
        run_frame(1, 8'h07, 0);
        @(negedge clk);
        run_frame(2, 8'h07, 0);
        @(negedge clk);

        // Back-to-back with valid held throughout.
        run_frame(0, 8'h00, 1);
        run_frame(0, 8'hFF, 0);
        @(negedge clk);

        // Reset during data bit 3 of 8'h3C (frame bit 4, cycles 16..19).
        din[0] = 8'h3C;
        vld[0] = 1'b1;
        check("ready_pre_rst", rdy[0], 1'b1);
        @(posedge clk);
        #1;
        vld[0] = 1'b0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            check("pre_rst_tx", tx[0], exp_bit(0, 8'h3C, i / 4));
            check("pre_rst_busy", busy[0], 1'b1);
        end
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_tx", tx[0], 1'b1);
        check("async_rst_busy", busy[0], 1'b0);
        check("async_rst_done", done[0], 1'b0);
        @(negedge clk);
        reset = 1'b0;
        idle_cycles(0, 30);
        run_frame(0, 8'h3C, 0);
        @(negedge clk);

        // One bit per clock, two stop bits, data wiggling mid-frame.
        run_frame(3, 8'h81, 2);
        @(negedge clk);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 4; k++) begin
                run_frame(k, 8'($urandom), int'($urandom_range(0, 2)));
                if ($urandom_range(0, 1) == 1) @(negedge clk);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
